// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL supervisor: FSM state codes and saturating-counter helpers.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package pll_sup_pkg;

    // FSM state codes; these values are visible on the state output.
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_e;

    // Width of the retries/relocks event counters.
    localparam int SAT_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
        return (v == {SAT_W{1'b1}}) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/pll_supervisor_sync2.sv
// Two-flop synchronizer for a single level signal, async active-high reset to 0.
// Latency: 2 clk_i edges from d_i sampled to q_o.
// Backpressure: none; a pulse narrower than one clk_i period may be missed.
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture; the first flop may go metastable, the second settles it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// PLL supervisor: pulses the PLL reset, waits for a stable lock, then releases system reset.
// Latency: locked-rise to sys_rst-fall is STABLE_CYCLES+3 edges; locked-fall in RUN to sys_rst-rise is 3.
// Backpressure: none. Optional macro PLL_SUPERVISOR_RETRY_LIMIT_EN adds a sticky FAIL state after MAX_RETRY timeouts.
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRY      = 8
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fail,
    output logic [2:0]       state,
    output logic [SAT_W-1:0] retries,
    output logic [SAT_W-1:0] relocks
);

    // One counter serves all timed states, so it is sized for the longest interval.
    localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             locked_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SAT_W-1:0] retries_q, retries_d;
    logic [SAT_W-1:0] relocks_q, relocks_d;
    logic             pll_rst_q, sys_rst_q, ready_q;

    sync2 u_lock_sync (
        .clk_i (clkin),
        .rst_i (rst),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    // Next-state, counter and event-counter logic; lock takes priority over a coincident timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        relocks_d = relocks_q;
        case (state_q)
            RESET_PLL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LST) begin
                    retries_d = sat_inc(retries_q);
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
                    state_d = (retries_q >= SAT_W'(MAX_RETRY - 1)) ? FAIL : RESET_PLL;
`else
                    state_d = RESET_PLL;
`endif
                end
            end
            STABLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    relocks_d = sat_inc(relocks_q);
                    state_d   = RESET_PLL;
                end
            end
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
            FAIL: begin
                state_d = FAIL;
            end
`endif
            default: begin
                state_d = RESET_PLL;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // State, counters and registered outputs; outputs are decoded from the next state so they
    // change on the same edge as the transition.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retries_q <= '0;
            relocks_q <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            relocks_q <= relocks_d;
            pll_rst_q <= (state_d == RESET_PLL) || (state_d == FAIL);
            sys_rst_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
        end
    end

`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
    logic fail_q;

    // Sticky failure flag; only rst leaves FAIL.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            fail_q <= 1'b0;
        end else begin
            fail_q <= (state_d == FAIL);
        end
    end

    assign fail = fail_q;
`else
    // Retries are unlimited in this build, so the retry cap has no effect.
    logic unused_max_retry;
    assign unused_max_retry = |MAX_RETRY;
    assign fail             = 1'b0;
`endif

    assign pll_rst = pll_rst_q;
    assign sys_rst = sys_rst_q;
    assign ready   = ready_q;
    assign state   = state_q;
    assign retries = retries_q;
    assign relocks = relocks_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor with short timing parameters.
// Edge numbering: edge 1 is the first rising clkin edge after rst falls; checks sample 1 ns after an edge.
// Table rows push their expectations into a scoreboard queue when driven and pop them after advancing.
module tb_pll_supervisor;

    localparam int P_RST   = 4;
    localparam int P_TO    = 32;
    localparam int P_STAB  = 8;
    localparam int P_RETRY = 3;

    logic       clkin;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [7:0] retries;
    logic [7:0] relocks;

    int n_tests = 0;
    int n_fail  = 0;

    pll_supervisor #(
        .PLL_RST_CYCLES (P_RST),
        .LOCK_TIMEOUT   (P_TO),
        .STABLE_CYCLES  (P_STAB),
        .MAX_RETRY      (P_RETRY)
    ) dut (
        .clkin   (clkin),
        .rst     (rst),
        .locked  (locked),
        .pll_rst (pll_rst),
        .sys_rst (sys_rst),
        .ready   (ready),
        .fail    (fail),
        .state   (state),
        .retries (retries),
        .relocks (relocks)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    typedef struct {
        int         adv;
        logic       lk;
        logic       pll;
        logic       sys;
        logic       rdy;
        logic [2:0] st;
        logic [7:0] rty;
        logic [7:0] rlk;
    } vec_t;

    vec_t vt[14];
    vec_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        locked = 1'b0;
        @(negedge clkin);
        @(negedge clkin);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pll_rst"}, 32'(pll_rst), 32'd1);
        chk({tag, ".sys_rst"}, 32'(sys_rst), 32'd1);
        chk({tag, ".ready"},   32'(ready),   32'd0);
        chk({tag, ".fail"},    32'(fail),    32'd0);
        chk({tag, ".state"},   32'(state),   32'd0);
        chk({tag, ".retries"}, 32'(retries), 32'd0);
        chk({tag, ".relocks"}, 32'(relocks), 32'd0);
    endtask

    initial begin
        vec_t e;

        // Normal lock (locked raised so edge 10 first samples it), then loss in RUN and re-lock.
        //          adv  lk    pll   sys   rdy   st    rty   rlk         edge after row
        vt[0]  = '{3,  1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 8'd0};  // 3: PLL reset pulse
        vt[1]  = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 8'd0, 8'd0};  // 4: pulse ends
        vt[2]  = '{5,  1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 8'd0, 8'd0};  // 9
        vt[3]  = '{2,  1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'd0, 8'd0};  // 11: still synchronizing
        vt[4]  = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 8'd0, 8'd0};  // 12: STABLE
        vt[5]  = '{7,  1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 8'd0, 8'd0};  // 19: one edge short
        vt[6]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'd0, 8'd0};  // 20: 11th edge, released
        vt[7]  = '{5,  1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'd0, 8'd0};  // 25
        vt[8]  = '{2,  1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'd0, 8'd0};  // 27: loss not yet seen
        vt[9]  = '{1,  1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 8'd1};  // 28: 3rd edge, reset
        vt[10] = '{3,  1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 8'd1};  // 31
        vt[11] = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 8'd0, 8'd1};  // 32: 4-cycle pulse done
        vt[12] = '{10, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 8'd0, 8'd1};  // 42
        vt[13] = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'd0, 8'd1};  // 43: re-released

        rst    = 1'b0;
        locked = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk_reset_vals("reset");

        rst = 1'b0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            locked = vt[i].lk;
            exp_q.push_back(vt[i]);
            tick(vt[i].adv);
            e = exp_q.pop_front();
            chk($sformatf("row%0d.pll_rst", i), 32'(pll_rst), 32'(e.pll));
            chk($sformatf("row%0d.sys_rst", i), 32'(sys_rst), 32'(e.sys));
            chk($sformatf("row%0d.ready", i),   32'(ready),   32'(e.rdy));
            chk($sformatf("row%0d.state", i),   32'(state),   32'(e.st));
            chk($sformatf("row%0d.retries", i), 32'(retries), 32'(e.rty));
            chk($sformatf("row%0d.relocks", i), 32'(relocks), 32'(e.rlk));
            chk($sformatf("row%0d.fail", i),    32'(fail),    32'd0);
        end

        // Async reset between edges while in RUN with relocks=1.
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");

        // Flicker in STABLE.
        do_reset();
        tick(4);
        locked = 1'b1;
        tick(3);
        chk("flick.enter_stable", 32'(state), 32'd2);
        tick(2);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(1);
        chk("flick.still_stable", 32'(state), 32'd2);
        tick(1);
        chk("flick.back_wait", 32'(state), 32'd1);
        tick(1);
        chk("flick.restable", 32'(state), 32'd2);
        tick(7);
        chk("flick.not_yet", 32'(sys_rst), 32'd1);
        tick(1);
        chk("flick.run", 32'(state), 32'd3);
        chk("flick.sys_rst", 32'(sys_rst), 32'd0);
        chk("flick.ready", 32'(ready), 32'd1);
        chk("flick.retries", 32'(retries), 32'd0);

        // Timeouts with locked held low: one per 36 edges.
        do_reset();
        tick(35);
        chk("to.wait_pll", 32'(pll_rst), 32'd0);
        chk("to.wait_rty", 32'(retries), 32'd0);
        tick(1);
        chk("to1.pll", 32'(pll_rst), 32'd1);
        chk("to1.state", 32'(state), 32'd0);
        chk("to1.rty", 32'(retries), 32'd1);
        tick(3);
        chk("to1.pll_end", 32'(pll_rst), 32'd1);
        tick(1);
        chk("to1.pll_low", 32'(pll_rst), 32'd0);
        tick(32);
        chk("to2.rty", 32'(retries), 32'd2);
        chk("to2.pll", 32'(pll_rst), 32'd1);
        tick(36);
        chk("to3.rty", 32'(retries), 32'd3);
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
        chk("to3.state", 32'(state), 32'd4);
        chk("to3.fail", 32'(fail), 32'd1);
        chk("to3.pll", 32'(pll_rst), 32'd1);
        tick(100);
        chk("fail.sticky_state", 32'(state), 32'd4);
        chk("fail.sticky_fail", 32'(fail), 32'd1);
        chk("fail.sticky_pll", 32'(pll_rst), 32'd1);
        chk("fail.sticky_sys", 32'(sys_rst), 32'd1);
        chk("fail.rty", 32'(retries), 32'd3);
`else
        chk("to3.state", 32'(state), 32'd0);
        chk("to3.fail", 32'(fail), 32'd0);
        tick(36 * 254 - 108);
        chk("sat.254", 32'(retries), 32'd254);
        tick(36);
        chk("sat.255", 32'(retries), 32'd255);
        tick(36 * 45);
        chk("sat.300", 32'(retries), 32'd255);
        chk("sat.state", 32'(state), 32'd0);
        chk("sat.fail", 32'(fail), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
